// File: rtl/xdma_rsp_manager_pkg.sv
// -----------------------------------------------------------------------------
// xdma_rsp_manager_pkg
// Shared types and defaults for the receive-side dispatcher.
// Contents:
//   rsp_state_e    - dispatcher FSM states (IDLE, BUSY)
//   LEN_W_DEFAULT  - default width of the beat-length field
//   N_OUP_DEFAULT  - default number of destination ports
// -----------------------------------------------------------------------------
package xdma_rsp_manager_pkg;

  localparam int unsigned LEN_W_DEFAULT = 16;
  localparam int unsigned N_OUP_DEFAULT = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/xdma_rsp_manager_if.sv
// -----------------------------------------------------------------------------
// xdma_rsp_manager_if
// Handshake bundle of the dispatcher: descriptor channel, one inbound stream
// and N_OUP outbound streams.
// Modports:
//   slave  - dispatcher view (takes descriptor + inbound beats, drives ports)
//   master - environment view (issues descriptors, feeds beats, sinks ports)
// Signals:
//   desc_i / dest_idx_i / len_i / desc_valid_i / desc_ready_o   descriptor
//   inp_data_i / inp_valid_i / inp_ready_o                      inbound beat
//   oup_data_o / oup_valid_o / oup_ready_i                      per-port beat
// -----------------------------------------------------------------------------
interface xdma_rsp_manager_if #(
  parameter type         data_t    = logic,
  parameter type         desc_t    = logic,
  parameter int unsigned N_OUP     = 2,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned LOG_N_OUP = $clog2(N_OUP)
);

  desc_t                  desc_i;
  logic [LOG_N_OUP-1:0]   dest_idx_i;
  logic [LEN_W-1:0]       len_i;
  logic                   desc_valid_i;
  logic                   desc_ready_o;

  data_t                  inp_data_i;
  logic                   inp_valid_i;
  logic                   inp_ready_o;

  data_t [N_OUP-1:0]      oup_data_o;
  logic  [N_OUP-1:0]      oup_valid_o;
  logic  [N_OUP-1:0]      oup_ready_i;

  modport slave (
    input  desc_i, dest_idx_i, len_i, desc_valid_i,
    output desc_ready_o,
    input  inp_data_i, inp_valid_i,
    output inp_ready_o,
    output oup_data_o, oup_valid_o,
    input  oup_ready_i
  );

  modport master (
    output desc_i, dest_idx_i, len_i, desc_valid_i,
    input  desc_ready_o,
    output inp_data_i, inp_valid_i,
    input  inp_ready_o,
    input  oup_data_o, oup_valid_o,
    output oup_ready_i
  );

endinterface

// File: rtl/xdma_rsp_manager_beat_counter.sv
// -----------------------------------------------------------------------------
// xdma_beat_counter
// Counts handshaken beats of one transfer and flags the last one.
// Ports:
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   clear_i   restart the count at zero (new transfer accepted)
//   en_i      one beat handshaken this cycle
//   target_i  transfer length in beats (non-zero while counting)
//   last_o    the beat being handshaken now is the final one
// Comparing against target-1 keeps the count below 2^LEN_W-1, so the longest
// representable transfer completes without the counter wrapping.
// -----------------------------------------------------------------------------
module xdma_beat_counter
  import xdma_rsp_manager_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [LEN_W-1:0] target_i,
  output logic             last_o
);

  logic [LEN_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + LEN_W'(1);
    end
  end

  assign last_o = (count_q == (target_i - LEN_W'(1)));

endmodule

// File: rtl/xdma_rsp_manager.sv
// -----------------------------------------------------------------------------
// xdma_rsp_manager
// Receive-side 1:N dispatcher. Accepts a descriptor (payload, destination,
// beat length), then steers the single inbound stream to the chosen port until
// LEN beats have handshaken, and pulses done_o on the last one.
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high; aborts any transfer
//   bus         descriptor / inbound / outbound handshakes (slave modport)
//   oup_desc_o  latched descriptor while BUSY, '0 otherwise
//   idx_o       latched destination index
//   busy_o      transfer in progress
//   done_o      single-cycle pulse on the last-beat handshake (or the cycle
//               after accepting a zero-length descriptor)
//   err_o       sticky: an out-of-range destination was accepted
// An out-of-range destination turns the transfer into a sink: beats are
// accepted and counted but no port sees valid.
// -----------------------------------------------------------------------------
module xdma_rsp_manager
  import xdma_rsp_manager_pkg::*;
#(
  parameter type         data_t          = logic,
  parameter type         xdma_req_desc_t = logic,
  parameter int unsigned N_OUP           = N_OUP_DEFAULT,
  parameter int unsigned LEN_W           = LEN_W_DEFAULT,
  localparam int unsigned LOG_N_OUP      = $clog2(N_OUP)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  xdma_rsp_manager_if.slave    bus,
  output xdma_req_desc_t       oup_desc_o,
  output logic [LOG_N_OUP-1:0] idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  rsp_state_e           state_q;
  xdma_req_desc_t       desc_q;
  logic [LOG_N_OUP-1:0] idx_q;
  logic [LEN_W-1:0]     len_q;
  logic                 illegal_q;
  logic                 err_q;
  logic                 zero_done_q;

  logic                 desc_accept;
  logic                 dest_illegal;
  logic                 beat_hs;
  logic                 last_beat;
  logic [N_OUP-1:0]     sel;

  // A zero-length transfer's done pulse holds off the next descriptor so that
  // done and acceptance never share a cycle.
  assign bus.desc_ready_o = (state_q == IDLE) && !zero_done_q;
  assign desc_accept      = bus.desc_valid_i && bus.desc_ready_o;
  assign dest_illegal     = (32'(bus.dest_idx_i) >= N_OUP);

  // One-hot port select; stays all-zero in IDLE and for sink transfers, which
  // also keeps an out-of-range index from ever addressing a port.
  // NOTE: combinational blocks assign a default to every output first so no
  // path can leave a value held, which would infer a latch.
  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(N_OUP); i++) begin
      if ((state_q == BUSY) && !illegal_q && (idx_q == LOG_N_OUP'(i))) begin
        sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    bus.oup_valid_o = '0;
    bus.oup_data_o  = '0;
    for (int i = 0; i < int'(N_OUP); i++) begin
      bus.oup_valid_o[i] = sel[i] && bus.inp_valid_i;
      bus.oup_data_o[i]  = sel[i] ? data_t'(bus.inp_data_i) : data_t'('0);
    end
  end

  assign bus.inp_ready_o = (state_q == BUSY) && (illegal_q || |(bus.oup_ready_i & sel));
  assign beat_hs         = bus.inp_valid_i && bus.inp_ready_o;

  xdma_beat_counter #(
    .LEN_W (LEN_W)
  ) i_beat_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (desc_accept),
    .en_i     (beat_hs),
    .target_i (len_q),
    .last_o   (last_beat)
  );

  // NOTE: every control register is reset synchronously; the descriptor
  // register is reset too so oup_desc_o is deterministic from the first cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      illegal_q   <= 1'b0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (desc_accept) begin
            desc_q    <= bus.desc_i;
            idx_q     <= bus.dest_idx_i;
            len_q     <= bus.len_i;
            illegal_q <= dest_illegal;
            if (dest_illegal) begin
              err_q <= 1'b1;
            end
            if (bus.len_i == '0) begin
              zero_done_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (beat_hs && last_beat) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oup_desc_o = (state_q == BUSY) ? desc_q : '0;
  assign idx_o      = idx_q;
  assign busy_o     = (state_q == BUSY);
  assign done_o     = zero_done_q || (beat_hs && last_beat);
  assign err_o      = err_q;

endmodule

// File: tb/tb_xdma_rsp_manager.sv
// -----------------------------------------------------------------------------
// tb_xdma_rsp_manager
// Directed bench for the receive-side dispatcher. Two instances:
//   dut4 - N_OUP=4, LEN_W=16: routing, backpressure, zero length,
//          back-to-back descriptors, mid-transfer reset
//   dut3 - N_OUP=3, LEN_W=4 : illegal destination, maximum length (15 beats)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Status vectors are {desc_ready, inp_ready, busy, done, err}.
// -----------------------------------------------------------------------------
module tb_xdma_rsp_manager;

  typedef logic [7:0]  data_t;
  typedef logic [15:0] desc_t;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xdma_rsp_manager_if #(.data_t(data_t), .desc_t(desc_t), .N_OUP(4), .LEN_W(16)) bus4 ();
  xdma_rsp_manager_if #(.data_t(data_t), .desc_t(desc_t), .N_OUP(3), .LEN_W(4))  bus3 ();

  desc_t       desc4, desc3;
  logic [1:0]  idx4, idx3;
  logic        busy4, done4, err4;
  logic        busy3, done3, err3;

  xdma_rsp_manager #(.data_t(data_t), .xdma_req_desc_t(desc_t), .N_OUP(4), .LEN_W(16)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4), .oup_desc_o(desc4), .idx_o(idx4),
    .busy_o(busy4), .done_o(done4), .err_o(err4)
  );

  xdma_rsp_manager #(.data_t(data_t), .xdma_req_desc_t(desc_t), .N_OUP(3), .LEN_W(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3), .oup_desc_o(desc3), .idx_o(idx3),
    .busy_o(busy3), .done_o(done3), .err_o(err3)
  );

  wire [4:0] st4 = {bus4.desc_ready_o, bus4.inp_ready_o, busy4, done4, err4};
  wire [4:0] st3 = {bus3.desc_ready_o, bus3.inp_ready_o, busy3, done3, err3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.desc_valid_i = 1'b0; bus4.desc_i = '0; bus4.dest_idx_i = '0; bus4.len_i = '0;
    bus4.inp_valid_i  = 1'b0; bus4.inp_data_i = '0; bus4.oup_ready_i = '0;
    bus3.desc_valid_i = 1'b0; bus3.desc_i = '0; bus3.dest_idx_i = '0; bus3.len_i = '0;
    bus3.inp_valid_i  = 1'b0; bus3.inp_data_i = '0; bus3.oup_ready_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL reset_status4: got %b expected %b", st4, 5'b10000); end
    n_checks++;
    if ({bus4.oup_valid_o, bus4.oup_data_o} !== 36'h0) begin
      n_fail++; $display("FAIL reset_ports4: got %h expected 0", {bus4.oup_valid_o, bus4.oup_data_o});
    end
    n_checks++;
    if ({desc4, idx4} !== 18'h0) begin n_fail++; $display("FAIL reset_desc_idx4: got %h expected 0", {desc4, idx4}); end
    n_checks++;
    if (st3 !== 5'b10000) begin n_fail++; $display("FAIL reset_status3: got %b expected %b", st3, 5'b10000); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_route();
    data_t       d;
    logic [31:0] exp_d;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'hA001; bus4.dest_idx_i = 2'd2; bus4.len_i = 16'd3;
    bus4.oup_ready_i  = 4'hF;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL route_accept: got %b expected %b", st4, 5'b10000); end
    tick();
    bus4.desc_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = 8'(17 * (k + 1));
      bus4.inp_valid_i = 1'b1; bus4.inp_data_i = d;
      exp_d = {8'h00, d, 16'h0000};
      @(negedge clk);
      n_checks++;
      if (bus4.oup_valid_o !== 4'b0100) begin n_fail++; $display("FAIL route_valid beat%0d: got %b expected 0100", k, bus4.oup_valid_o); end
      n_checks++;
      if (bus4.oup_data_o !== exp_d) begin n_fail++; $display("FAIL route_data beat%0d: got %h expected %h", k, bus4.oup_data_o, exp_d); end
      n_checks++;
      if (st4 !== {1'b0, 1'b1, 1'b1, (k == 2), 1'b0}) begin
        n_fail++; $display("FAIL route_status beat%0d: got %b expected %b", k, st4, {1'b0, 1'b1, 1'b1, (k == 2), 1'b0});
      end
      n_checks++;
      if ({desc4, idx4} !== {16'hA001, 2'd2}) begin n_fail++; $display("FAIL route_desc_idx beat%0d: got %h expected %h", k, {desc4, idx4}, {16'hA001, 2'd2}); end
      tick();
    end
    bus4.inp_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({st4, desc4} !== {5'b10000, 16'h0000}) begin n_fail++; $display("FAIL route_release: got %h expected %h", {st4, desc4}, {5'b10000, 16'h0000}); end
    tick();
  endtask

  task automatic test_backpressure();
    int          beat = 0;
    int          hs   = 0;
    logic        r;
    data_t       d;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'hB004; bus4.dest_idx_i = 2'd1; bus4.len_i = 16'd4;
    tick();
    bus4.desc_valid_i = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      r = (cyc % 2 == 0);
      d = 8'(8'hA0 + beat);
      bus4.inp_valid_i = 1'b1; bus4.inp_data_i = d;
      bus4.oup_ready_i = {1'b1, 1'b1, r, 1'b1};
      @(negedge clk);
      if (bus4.inp_ready_o) hs++;
      n_checks++;
      if (st4 !== {1'b0, r, 1'b1, (r && beat == 3), 1'b0}) begin
        n_fail++; $display("FAIL bp_status cyc%0d: got %b expected %b", cyc, st4, {1'b0, r, 1'b1, (r && beat == 3), 1'b0});
      end
      n_checks++;
      if ({bus4.oup_valid_o, bus4.oup_data_o} !== {4'b0010, 16'h0000, d, 8'h00}) begin
        n_fail++; $display("FAIL bp_port cyc%0d: got %h expected %h", cyc, {bus4.oup_valid_o, bus4.oup_data_o}, {4'b0010, 16'h0000, d, 8'h00});
      end
      tick();
      if (r) beat++;
    end
    bus4.inp_valid_i = 1'b0; bus4.oup_ready_i = 4'hF;
    @(negedge clk);
    n_checks++;
    if (hs !== 4) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL bp_release: got %b expected %b", st4, 5'b10000); end
    tick();
  endtask

  task automatic test_zero_length();
    bus4.inp_valid_i  = 1'b1; bus4.inp_data_i = 8'hEE; bus4.oup_ready_i = 4'hF;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'hBEEF; bus4.dest_idx_i = 2'd3; bus4.len_i = 16'd0;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL zero_accept: got %b expected %b", st4, 5'b10000); end
    tick();
    bus4.desc_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({st4, bus4.oup_valid_o} !== {5'b00010, 4'b0000}) begin
      n_fail++; $display("FAIL zero_done: got %b expected %b", {st4, bus4.oup_valid_o}, {5'b00010, 4'b0000});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL zero_after: got %b expected %b", st4, 5'b10000); end
    tick();
    bus4.inp_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus4.oup_ready_i  = 4'hF;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'h0B01; bus4.dest_idx_i = 2'd0; bus4.len_i = 16'd2;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL b2b_accept1: got %b expected %b", st4, 5'b10000); end
    tick();
    bus4.desc_i = 16'h0B02; bus4.dest_idx_i = 2'd3; bus4.len_i = 16'd2;
    for (int k = 0; k < 2; k++) begin
      bus4.inp_valid_i = 1'b1; bus4.inp_data_i = 8'(8'h51 + k);
      @(negedge clk);
      n_checks++;
      if ({st4, bus4.oup_valid_o, bus4.oup_data_o} !== {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b0001, 24'h0, 8'(8'h51 + k)}) begin
        n_fail++; $display("FAIL b2b_first beat%0d: got %h expected %h", k, {st4, bus4.oup_valid_o, bus4.oup_data_o},
                           {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b0001, 24'h0, 8'(8'h51 + k)});
      end
      tick();
    end
    bus4.inp_data_i = 8'h61;
    @(negedge clk);
    n_checks++;
    if ({st4, bus4.oup_valid_o} !== {5'b10000, 4'b0000}) begin
      n_fail++; $display("FAIL b2b_bubble: got %b expected %b", {st4, bus4.oup_valid_o}, {5'b10000, 4'b0000});
    end
    tick();
    bus4.desc_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus4.inp_data_i = 8'(8'h61 + k);
      @(negedge clk);
      n_checks++;
      if ({st4, bus4.oup_valid_o, bus4.oup_data_o} !== {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b1000, 8'(8'h61 + k), 24'h0}) begin
        n_fail++; $display("FAIL b2b_second beat%0d: got %h expected %h", k, {st4, bus4.oup_valid_o, bus4.oup_data_o},
                           {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b1000, 8'(8'h61 + k), 24'h0});
      end
      n_checks++;
      if ({desc4, idx4} !== {16'h0B02, 2'd3}) begin n_fail++; $display("FAIL b2b_desc_idx beat%0d: got %h expected %h", k, {desc4, idx4}, {16'h0B02, 2'd3}); end
      tick();
    end
    bus4.inp_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL b2b_release: got %b expected %b", st4, 5'b10000); end
    tick();
  endtask

  task automatic test_max_len();
    bus3.oup_ready_i  = 3'b111;
    bus3.desc_valid_i = 1'b1; bus3.desc_i = 16'h0D0F; bus3.dest_idx_i = 2'd1; bus3.len_i = 4'hF;
    @(negedge clk);
    n_checks++;
    if (st3 !== 5'b10000) begin n_fail++; $display("FAIL maxlen_accept: got %b expected %b", st3, 5'b10000); end
    tick();
    bus3.desc_valid_i = 1'b0;
    for (int k = 0; k < 15; k++) begin
      bus3.inp_valid_i = 1'b1; bus3.inp_data_i = 8'(k + 1);
      @(negedge clk);
      n_checks++;
      if ({st3, bus3.oup_valid_o} !== {1'b0, 1'b1, 1'b1, (k == 14), 1'b0, 3'b010}) begin
        n_fail++; $display("FAIL maxlen_beat%0d: got %b expected %b", k, {st3, bus3.oup_valid_o}, {1'b0, 1'b1, 1'b1, (k == 14), 1'b0, 3'b010});
      end
      tick();
    end
    bus3.inp_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st3 !== 5'b10000) begin n_fail++; $display("FAIL maxlen_release: got %b expected %b", st3, 5'b10000); end
    tick();
  endtask

  task automatic test_illegal_dest();
    bus3.oup_ready_i  = 3'b000;
    bus3.desc_valid_i = 1'b1; bus3.desc_i = 16'h0C03; bus3.dest_idx_i = 2'd3; bus3.len_i = 4'd2;
    @(negedge clk);
    n_checks++;
    if (st3 !== 5'b10000) begin n_fail++; $display("FAIL illegal_accept: got %b expected %b", st3, 5'b10000); end
    tick();
    bus3.desc_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus3.inp_valid_i = 1'b1; bus3.inp_data_i = 8'(8'h71 + k);
      @(negedge clk);
      n_checks++;
      if (st3 !== {1'b0, 1'b1, 1'b1, (k == 1), 1'b1}) begin
        n_fail++; $display("FAIL illegal_status beat%0d: got %b expected %b", k, st3, {1'b0, 1'b1, 1'b1, (k == 1), 1'b1});
      end
      n_checks++;
      if ({bus3.oup_valid_o, bus3.oup_data_o} !== 27'h0) begin
        n_fail++; $display("FAIL illegal_ports beat%0d: got %h expected 0", k, {bus3.oup_valid_o, bus3.oup_data_o});
      end
      tick();
    end
    bus3.inp_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st3 !== 5'b10001) begin n_fail++; $display("FAIL illegal_sticky: got %b expected %b", st3, 5'b10001); end
    tick();
  endtask

  task automatic test_mid_reset();
    bus4.oup_ready_i  = 4'hF;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'h0E05; bus4.dest_idx_i = 2'd2; bus4.len_i = 16'd5;
    tick();
    bus4.desc_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus4.inp_valid_i = 1'b1; bus4.inp_data_i = 8'(8'h81 + k);
      @(negedge clk);
      n_checks++;
      if (st4 !== 5'b01100) begin n_fail++; $display("FAIL mrst_beat%0d: got %b expected %b", k, st4, 5'b01100); end
      tick();
    end
    rst = 1'b1;
    bus4.inp_data_i = 8'h83;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL mrst_status: got %b expected %b", st4, 5'b10000); end
    n_checks++;
    if ({bus4.oup_valid_o, bus4.oup_data_o, desc4, idx4} !== 54'h0) begin
      n_fail++; $display("FAIL mrst_outputs: got %h expected 0", {bus4.oup_valid_o, bus4.oup_data_o, desc4, idx4});
    end
    n_checks++;
    if (st3 !== 5'b10000) begin n_fail++; $display("FAIL mrst_err_cleared: got %b expected %b", st3, 5'b10000); end
    tick();
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL mrst_no_done: got %b expected %b", st4, 5'b10000); end
    tick();
    bus4.inp_valid_i  = 1'b0;
    bus4.desc_valid_i = 1'b1; bus4.desc_i = 16'h0E02; bus4.dest_idx_i = 2'd1; bus4.len_i = 16'd2;
    tick();
    bus4.desc_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus4.inp_valid_i = 1'b1; bus4.inp_data_i = 8'(8'h91 + k);
      @(negedge clk);
      n_checks++;
      if ({st4, bus4.oup_valid_o} !== {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b0010}) begin
        n_fail++; $display("FAIL mrst_new beat%0d: got %b expected %b", k, {st4, bus4.oup_valid_o}, {1'b0, 1'b1, 1'b1, (k == 1), 1'b0, 4'b0010});
      end
      tick();
    end
    bus4.inp_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st4 !== 5'b10000) begin n_fail++; $display("FAIL mrst_new_release: got %b expected %b", st4, 5'b10000); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_backpressure();
    test_zero_length();
    test_back_to_back();
    test_max_len();
    test_illegal_dest();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
